// File: rtl/yarvi_mq_pkg.sv
// Shared definitions for the ex->me memory request queue: address/data
// widths, access-size encodings, the queued entry layout and the
// natural-alignment rule.
package yarvi_mq_pkg;

   // Most significant bit of a virtual address and of an integer register.
   localparam int VMSB = 31;
   localparam int XMSB = 31;

   // log2 of the access size in bytes.
   localparam logic [1:0] SIZE_BYTE   = 2'd0;
   localparam logic [1:0] SIZE_HALF   = 2'd1;
   localparam logic [1:0] SIZE_WORD   = 2'd2;
   localparam logic [1:0] SIZE_DOUBLE = 2'd3;

   // One queued memory request, exactly as ex hands it over.
   typedef struct packed {
      logic          writeenable;
      logic [VMSB:0] address;
      logic [XMSB:0] writedata;
      logic [1:0]    sizelg2;
      logic [4:0]    readtag;
      logic          readsignextend;
   } mq_entry_t;

   // An access is aligned when the low sizelg2 address bits are all zero.
   function automatic logic is_aligned(input logic [VMSB:0] address,
                                       input logic [1:0]    sizelg2);
      logic ok;
      ok = 1'b1;
      case (sizelg2)
         SIZE_BYTE:   ok = 1'b1;
         SIZE_HALF:   ok = (address[0] == 1'b0);
         SIZE_WORD:   ok = (address[1:0] == 2'b00);
         SIZE_DOUBLE: ok = (address[2:0] == 3'b000);
         default:     ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/yarvi_mq.sv
// Memory request queue between ex and me. Requests from ex are checked for
// natural alignment; aligned ones are queued in a DEPTH-entry register
// array and presented to me in FIFO order with at least one cycle of
// latency. Misaligned ones are dropped and reported for one cycle.
module yarvi_mq
   import yarvi_mq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                          clock,
   input  logic                          reset,

   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          in_writeenable,
   input  logic [VMSB:0]                 in_address,
   input  logic [XMSB:0]                 in_writedata,
   input  logic [1:0]                    in_sizelg2,
   input  logic [4:0]                    in_readtag,
   input  logic                          in_readsignextend,

   output logic                          out_valid,
   output logic                          out_writeenable,
   output logic [VMSB:0]                 out_address,
   output logic [XMSB:0]                 out_writedata,
   output logic [1:0]                    out_sizelg2,
   output logic [4:0]                    out_readtag,
   output logic                          out_readsignextend,
   input  logic                          me_ready,

   input  logic                          flush,

   output logic                          misaligned,
   output logic [VMSB:0]                 misaligned_address,

   output logic [$clog2(DEPTH):0]        count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Payload storage; deliberately not reset, out_* are only meaningful
   // while out_valid is high.
   mq_entry_t      mem_q [DEPTH];

   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             mis_q, mis_d;
   logic [VMSB:0]    mis_addr_q, mis_addr_d;

   logic             aligned;
   logic             handshake;
   logic             push;
   logic             pop;
   mq_entry_t        in_entry;
   mq_entry_t        head;

   // Readiness and visibility come only from registered occupancy, so a pop
   // at full never opens room for a push in the same cycle.
   assign in_ready  = (count_q != CNT_W'(DEPTH));
   assign out_valid = (count_q != '0);
   assign count     = count_q;

   assign misaligned         = mis_q;
   assign misaligned_address = mis_addr_q;

   // Head entry straight from storage; no path from in_* to out_*.
   assign head               = mem_q[rptr_q];
   assign out_writeenable    = head.writeenable;
   assign out_address        = head.address;
   assign out_writedata      = head.writedata;
   assign out_sizelg2        = head.sizelg2;
   assign out_readtag        = head.readtag;
   assign out_readsignextend = head.readsignextend;

   // Handshake decode and next-state for pointers, occupancy and fault report.
   always_comb begin
      in_entry.writeenable    = in_writeenable;
      in_entry.address        = in_address;
      in_entry.writedata      = in_writedata;
      in_entry.sizelg2        = in_sizelg2;
      in_entry.readtag        = in_readtag;
      in_entry.readsignextend = in_readsignextend;

      aligned   = is_aligned(in_address, in_sizelg2);
      // A request squashed by flush is neither queued nor reported.
      handshake = in_valid && in_ready && !flush;
      push      = handshake && aligned;
      // A pop in a flush cycle still counts as delivered to me.
      pop       = out_valid && me_ready;

      rptr_d     = pop ? rptr_q + PTR_W'(1) : rptr_q;
      wptr_d     = push ? wptr_q + PTR_W'(1) : wptr_q;
      count_d    = count_q;
      mis_d      = handshake && !aligned;
      mis_addr_d = mis_addr_q;

      if (handshake && !aligned) begin
         mis_addr_d = in_address;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // Flush empties the queue by collapsing the write pointer onto the
      // post-pop read pointer.
      if (flush) begin
         count_d = '0;
         wptr_d  = rptr_d;
      end
   end

   // Control state; reset overrides flush, push and pop.
   always_ff @(posedge clock) begin
      if (reset) begin
         rptr_q     <= '0;
         wptr_q     <= '0;
         count_q    <= '0;
         mis_q      <= 1'b0;
         mis_addr_q <= '0;
      end else begin
         rptr_q     <= rptr_d;
         wptr_q     <= wptr_d;
         count_q    <= count_d;
         mis_q      <= mis_d;
         mis_addr_q <= mis_addr_d;
      end
   end

   // One write-enabled register per entry, selected by the write pointer.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         // Capture the incoming request into this slot when it is the tail.
         always_ff @(posedge clock) begin
            if (!reset && push && (wptr_q == PTR_W'(gi))) begin
               mem_q[gi] <= in_entry;
            end
         end
      end
   endgenerate

endmodule

// File: doc/yarvi_mq.md
YARVI_MQ -- requirements
Module: yarvi_mq

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entry count; legal values are powers of two from 2 to 16.
REQ-002 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, request from ex is present.
REQ-005 SHALL have port in_ready, output, 1, queue accepts a request this cycle.
REQ-006 SHALL have ports in_writeenable (1), in_address (`VMSB+1), in_writedata (`XMSB+1), in_sizelg2 (2), in_readtag (5), in_readsignextend (1), all inputs, forming the ex memory request.
REQ-007 SHALL have port out_valid, output, 1, head request presented to me.
REQ-008 SHALL have ports out_writeenable, out_address, out_writedata, out_sizelg2, out_readtag, out_readsignextend, all outputs, with widths matching REQ-006, carrying the head entry.
REQ-009 SHALL have port me_ready, input, 1, me consumes the head this cycle.
REQ-010 SHALL have port flush, input, 1, discard all queued requests.
REQ-011 SHALL have ports misaligned (output, 1) and misaligned_address (output, `VMSB+1), forming the fault report.
REQ-012 SHALL have port count, output, log2(DEPTH)+1, occupancy.

Function
REQ-013 SHALL accept (push) when in_valid && in_ready && !flush && aligned.
REQ-014 SHALL define aligned as in_address bits [sizelg2-1:0] all zero: size 0 is always aligned; sizes 1, 2 and 3 check bits [0], [1:0] and [2:0].
REQ-015 SHALL drive in_ready = (count != DEPTH), derived only from registered count; a pop in the same cycle SHALL NOT admit a push at full.
REQ-016 SHALL drop a misaligned request that meets the handshake, without queuing it; in the next cycle misaligned SHALL be 1 for exactly one cycle and misaligned_address SHALL hold that address.
REQ-017 SHALL drive out_valid = (count != 0) and out_* from the head entry register; there is no combinational path from in_* to out_*.
REQ-018 SHALL pop the head when out_valid && me_ready.
REQ-019 SHALL make an entry visible at out_valid exactly 1 cycle after its push (minimum latency 1; no bypass when empty).
REQ-020 SHALL, on simultaneous push and pop, leave count unchanged and preserve FIFO order.
REQ-021 SHALL implement read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH.
REQ-022 SHALL, on flush, set count=0 and pointers equal next cycle; a push in the flush cycle SHALL be discarded; a pop in the flush cycle SHALL still count as issued to me.
REQ-023 SHALL hold out_* stable while out_valid && !me_ready.
REQ-024 SHALL keep count equal to pushes minus pops since the last reset or flush, never exceeding DEPTH and never underflowing.

Reset
REQ-025 SHALL, on reset, set count=0, pointers=0, out_valid=0, in_ready=1, misaligned=0, misaligned_address=0.
REQ-026 SHALL give reset priority over flush, push, and pop in the same cycle.
REQ-027 SHALL leave entry payload storage unreset; out_* payload outputs are don't-care while out_valid=0.

Structure
REQ-028 SHALL take `VMSB and `XMSB from yarvi.h; the sizelg2 encodings (byte=0, half=1, word=2, double=3) SHALL be added to yarvi.h as shared constants.
REQ-029 SHALL be a single module with no sub-modules; storage is a DEPTH-entry register array.
REQ-030 SHALL be instantiated in the yarvi top level between ex (ex_mem_*) and me, with ex driving in_valid from ex_mem_valid and flush from ex_restart.

Verification
REQ-031 SHALL verify: push 4 stores with me_ready=0 -> count=4, in_ready=0; raise me_ready -> 4 pops in order over 4 cycles, then count=0.
REQ-032 SHALL verify: at count=4, in_valid=1 and me_ready=1 in the same cycle -> pop occurs, push refused, count=3.
REQ-033 SHALL verify: a load with sizelg2=2, address 0x1002 -> not queued; misaligned=1 for one cycle with misaligned_address=0x1002; count unchanged.
REQ-034 SHALL verify: count=3 with flush=1 and a push in the same cycle -> count=0 next cycle and out_valid=0.
REQ-035 SHALL verify: 10 continuous push/pop pairs with me_ready=1 -> pointers wrap, out_readtag sequence matches input order, and count stays at 1.
REQ-036 SHALL verify: reset asserted while count=2 -> next cycle count=0, in_ready=1, out_valid=0.
